// File: rtl/math_cabs_sched.sv
// math_cabs_sched: round-robin sharing of one fixed-latency cabs pipeline,
// with tags carried alongside the pipeline and credit-protected responses.
module math_cabs_sched #(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int LATENCY    = 14,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [32*NUM_REQ-1:0]   req_dina,
  input  logic [32*NUM_REQ-1:0]   req_dinb,
  output logic [31:0]             cabs_dina,
  output logic [31:0]             cabs_dinb,
  input  logic [33:0]             cabs_dout,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [33:0]             rsp_data
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [ID_W-1:0] r_ptr, w_g, w_c;
  logic w_found, w_xfer, w_pop, w_wr, w_credit;
  logic [AW:0] r_out, r_wp, r_rp, w_post;
  logic [LATENCY:0] r_tv;
  logic [ID_W-1:0] r_tid [LATENCY+1];
  logic [ID_W+33:0] r_mem [FIFO_DEPTH];

  always_comb begin
    w_found = 1'b0;
    w_g = r_ptr;
    w_c = r_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_c = ID_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[w_c]) begin
        w_found = 1'b1;
        w_g = w_c;
      end
    end
  end

  assign rsp_valid = r_wp != r_rp;
  assign w_pop = rsp_valid & rsp_ready;
  // post-pop count lets a pop at full credit re-open issue in the same cycle
  assign w_post = r_out - (AW+1)'(w_pop);
  assign w_credit = int'(w_post) < FIFO_DEPTH;
  assign w_xfer = w_found & w_credit & ~rst;
  assign req_ready = w_xfer ? NUM_REQ'(1) << w_g : '0;
  assign w_wr = r_tv[LATENCY];
  assign {rsp_id, rsp_data} = r_mem[r_rp[AW-1:0]];

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_ptr <= '0;
      r_out <= '0;
      r_tv <= '0;
      r_wp <= '0;
      r_rp <= '0;
      cabs_dina <= '0;
      cabs_dinb <= '0;
    end else begin
      r_tv <= {r_tv[LATENCY-1:0], w_xfer};
      r_out <= r_out + (AW+1)'(w_xfer) - (AW+1)'(w_pop);
      if (w_wr) r_wp <= r_wp + (AW+1)'(1);
      if (w_pop) r_rp <= r_rp + (AW+1)'(1);
      if (w_xfer) begin
        r_ptr <= (int'(w_g) == NUM_REQ-1) ? '0 : w_g + ID_W'(1);
        cabs_dina <= req_dina[32*w_g +: 32];
        cabs_dinb <= req_dinb[32*w_g +: 32];
      end
    end

  always_ff @(posedge clk) begin
    r_tid[0] <= w_g;
    for (int i = 1; i <= LATENCY; i++) r_tid[i] <= r_tid[i-1];
    if (w_wr) r_mem[r_wp[AW-1:0]] <= {r_tid[LATENCY], cabs_dout};
  end

  assert property (@(posedge clk) disable iff (rst)
    !(w_wr && r_wp == {~r_rp[AW], r_rp[AW-1:0]}));
endmodule

// File: tb/tb_math_cabs_sched.sv
// tb_math_cabs_sched: randomized scoreboard bench for the shared cabs scheduler.
module tb_math_cabs_sched;
  localparam int N = 4, LAT = 14, D = 16;
  logic clk = 0, rst = 1;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [32*N-1:0] req_dina = '0, req_dinb = '0;
  logic [31:0] cabs_dina, cabs_dinb;
  logic [33:0] cabs_dout, rsp_data;
  logic rsp_valid, rsp_ready = 0;
  logic [1:0] rsp_id;
  logic [33:0] dly [LAT];
  logic [35:0] exp_q [$];
  int checks = 0, failures = 0, m_ptr = 0, m_out = 0, n_xfer = 0;

  always #5 clk = ~clk;

  math_cabs_sched #(.NUM_REQ(N), .ID_W(2), .LATENCY(LAT), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_dina(req_dina), .req_dinb(req_dinb), .cabs_dina(cabs_dina), .cabs_dinb(cabs_dinb),
    .cabs_dout(cabs_dout), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data));

  // stand-in cabs pipeline: pure delay of the real operand, so routing is visible by value
  always @(posedge clk) begin
    dly[0] <= {2'b00, cabs_dina};
    for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
  end
  assign cabs_dout = dly[LAT-1];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // reference: round-robin grant and credit count, pushing expected responses
  always @(negedge clk) begin
    int g;
    logic pop;
    logic [N-1:0] er;
    if (rst) begin
      m_ptr = 0;
      m_out = 0;
      exp_q.delete();
    end else begin
      pop = rsp_valid && rsp_ready;
      er = '0;
      g = -1;
      if (m_out - int'(pop) < D)
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      if (g >= 0) er[g] = 1'b1;
      chk("req_ready", req_ready, er);
      if (g >= 0) begin
        exp_q.push_back({2'(g), 2'b00, req_dina[32*g +: 32]});
        m_ptr = (g + 1) % N;
        m_out++;
        n_xfer++;
      end
      if (pop) m_out--;
    end
  end

  always @(negedge clk) begin
    logic [35:0] e;
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) chk("spurious_rsp", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("rsp_id", rsp_id, e[35:34]);
        chk("rsp_data", rsp_data, e[33:0]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic randdata();
    req_dina = {$urandom, $urandom, $urandom, $urandom};
    req_dinb = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic drain();
    int t = 0;
    cyc();
    req_valid = '0;
    rsp_ready = 1;
    while ((exp_q.size() != 0 || rsp_valid) && t < 200) begin
      cyc();
      t++;
    end
    chk("drain_timeout", t < 200, 1);
  endtask

  task automatic single(int id, logic [31:0] a, logic [31:0] b);
    cyc();
    rsp_ready = 1;
    req_valid = N'(1) << id;
    req_dina[32*id +: 32] = a;
    req_dinb[32*id +: 32] = b;
    @(negedge clk);
    chk("single_grant", req_ready, N'(1) << id);
    cyc();
    req_valid = '0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) chk("issue_dina", cabs_dina, a);
      if (k == 1) chk("issue_dinb", cabs_dinb, b);
      chk("single_latency", rsp_valid, k == 16);
      if (k < 16) cyc();
    end
  endtask

  initial begin
    int c0;
    req_valid = '1;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cabs_dina", cabs_dina, 0);
    cyc();
    rst = 0;
    req_valid = '0;
    single(2, 32'd3, 32'd4);
    drain();
    for (int i = 0; i < 40; i++) begin
      cyc();
      randdata();
      req_valid = '1;
    end
    drain();
    for (int i = 0; i < 20; i++) begin
      cyc();
      randdata();
      req_valid = 4'b0010;
      @(negedge clk);
      chk("solo_ready", req_ready[1], 1);
    end
    drain();
    c0 = n_xfer;
    cyc();
    rsp_ready = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      randdata();
      req_valid = '1;
    end
    cyc();
    chk("bp_xfers", n_xfer - c0, 16);
    chk("bp_stall", req_ready, 0);
    rsp_ready = 1;
    #1;
    chk("bp_resume", |req_ready, 1);
    for (int i = 0; i < 20; i++) begin
      cyc();
      randdata();
    end
    drain();
    for (int i = 0; i < 300; i++) begin
      cyc();
      randdata();
      req_valid = N'($urandom);
      rsp_ready = $urandom_range(0, 1);
    end
    drain();
    for (int i = 0; i < 8; i++) begin
      cyc();
      randdata();
      req_valid = '1;
    end
    cyc();
    req_valid = '0;
    repeat (4) cyc();
    rst = 1;
    @(negedge clk);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_req_ready", req_ready, 0);
    cyc();
    rst = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      @(negedge clk);
      chk("no_stale", rsp_valid, 0);
    end
    single(3, 32'h1234, 32'h5678);
    drain();
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
